// File: rtl/dpll_phase_filter.sv
// rtl/dpll_phase_filter.sv - Bang-bang phase detector and random-walk K-counter loop filter
`timescale 1ns/1ps
module dpll_phase_filter #(
   parameter int K          = 8,
   parameter int HOLDOFF    = 4,
   parameter int LOCK_EDGES = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   enable_i,
   input  logic                   ref_i,
   input  logic                   fb_i,
   output logic                   positiveShift_o,
   output logic                   negativeShift_o,
   output logic [$clog2(K)+1:0]   vote_cnt_o,
   output logic                   locked_o
);

   localparam int CW = $clog2(K) + 2;
   localparam logic signed [CW-1:0] CNT_POS   = CW'(K);
   localparam logic signed [CW-1:0] CNT_NEG   = CW'(-K);
   localparam logic signed [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [7:0]           HOLD_LOAD = 8'(HOLDOFF);
   localparam logic [15:0]          LOCK_MAX  = 16'(LOCK_EDGES);

   logic ref_meta_q, ref_meta_d;
   logic ref_s_q, ref_s_d;
   logic ref_dly_q, ref_dly_d;
   logic fb_meta_q, fb_meta_d;
   logic fb_s_q, fb_s_d;

   logic signed [CW-1:0] cnt_q, cnt_d;
   logic                 pos_q, pos_d;
   logic                 neg_q, neg_d;
   logic [7:0]           hold_q, hold_d;
   logic [15:0]          lock_cnt_q, lock_cnt_d;
   logic                 locked_q, locked_d;

   logic                 edge_cycle;
   logic                 pulse_now;
   logic                 vote_ok;
   logic signed [CW-1:0] cnt_next;

   // Two-flop synchronizers for ref/fb plus the delayed ref copy used for edge detection
   always_comb begin
      ref_meta_d = ref_i;
      ref_s_d    = ref_meta_q;
      ref_dly_d  = ref_s_q;
      fb_meta_d  = fb_i;
      fb_s_d     = fb_meta_q;
   end

   // Vote on each ref rising edge, integrate in the K-counter, manage holdoff and lock
   always_comb begin
      edge_cycle = ref_s_q & ~ref_dly_q;
      pulse_now  = pos_q | neg_q;
      vote_ok    = edge_cycle && (hold_q == 8'd0);
      // fb still low at the ref edge means feedback is late: count up
      cnt_next   = fb_s_q ? (cnt_q - CNT_ONE) : (cnt_q + CNT_ONE);

      cnt_d      = cnt_q;
      pos_d      = 1'b0;
      neg_d      = 1'b0;
      hold_d     = hold_q;
      lock_cnt_d = lock_cnt_q;

      if (!enable_i) begin
         cnt_d      = '0;
         hold_d     = '0;
         lock_cnt_d = '0;
      end else begin
         if (vote_ok) begin
            if (cnt_next == CNT_POS) begin
               pos_d = 1'b1;
               cnt_d = '0;
            end else if (cnt_next == CNT_NEG) begin
               neg_d = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_next;
            end
         end

         if (pulse_now) begin
            hold_d = HOLD_LOAD;
         end else if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
         end

         // A shift pulse restarts the lock qualification; discarded edges still count
         if (pulse_now) begin
            lock_cnt_d = '0;
         end else if (edge_cycle && (lock_cnt_q != LOCK_MAX)) begin
            lock_cnt_d = lock_cnt_q + 16'd1;
         end
      end

      // Looks at the next lock count so the flag drops the cycle right after a pulse
      locked_d = (lock_cnt_d == LOCK_MAX);
   end

   // Synchronizer and edge register state
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ref_meta_q <= 1'b0;
         ref_s_q    <= 1'b0;
         ref_dly_q  <= 1'b0;
         fb_meta_q  <= 1'b0;
         fb_s_q     <= 1'b0;
      end else begin
         ref_meta_q <= ref_meta_d;
         ref_s_q    <= ref_s_d;
         ref_dly_q  <= ref_dly_d;
         fb_meta_q  <= fb_meta_d;
         fb_s_q     <= fb_s_d;
      end
   end

   // Loop filter state: counter, shift pulses, holdoff timer and lock tracking
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q      <= '0;
         pos_q      <= 1'b0;
         neg_q      <= 1'b0;
         hold_q     <= '0;
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         pos_q      <= pos_d;
         neg_q      <= neg_d;
         hold_q     <= hold_d;
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
      end
   end

   assign positiveShift_o = pos_q;
   assign negativeShift_o = neg_q;
   assign vote_cnt_o      = cnt_q;
   assign locked_o        = locked_q;

endmodule

// File: tb/tb_dpll_phase_filter.sv
// tb/tb_dpll_phase_filter.sv - Self-checking bench for dpll_phase_filter
`timescale 1ns/1ps
module tb_dpll_phase_filter;

   localparam int K          = 4;
   localparam int HOLDOFF    = 4;
   localparam int LOCK_EDGES = 8;
   localparam int W          = $clog2(K) + 2;

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic         enable_i;
   logic         ref_i;
   logic         fb_i;
   logic         positiveShift_o;
   logic         negativeShift_o;
   logic [W-1:0] vote_cnt_o;
   logic         locked_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state, advanced once per clock edge
   int cyc = 0;
   int m_cnt;
   int m_lock;
   int last_pulse;
   bit m_pos;
   bit m_neg;
   bit m_locked;
   int edge_n_q[$];
   bit edge_fb_q[$];

   // Per-scenario observations
   int           bad_cycles;
   int           first_bad_cyc;
   logic [W+2:0] first_bad_obs;
   logic [W+2:0] first_bad_exp;
   int           pos_seen;
   int           neg_seen;
   int           both_seen;
   int           locked_seen;

   dpll_phase_filter #(
      .K          (K),
      .HOLDOFF    (HOLDOFF),
      .LOCK_EDGES (LOCK_EDGES)
   ) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .enable_i        (enable_i),
      .ref_i           (ref_i),
      .fb_i            (fb_i),
      .positiveShift_o (positiveShift_o),
      .negativeShift_o (negativeShift_o),
      .vote_cnt_o      (vote_cnt_o),
      .locked_o        (locked_o)
   );

   always #2.5 clk_i = ~clk_i;

   function automatic void model_reset();
      m_cnt      = 0;
      m_lock     = 0;
      last_pulse = -1000;
      m_pos      = 1'b0;
      m_neg      = 1'b0;
      m_locked   = 1'b0;
      edge_n_q.delete();
      edge_fb_q.delete();
   endfunction

   // Outputs expected after clock edge number cyc. A ref edge first sampled at
   // edge n is voted at edge n+2; the pulse is visible from n+2 to n+3.
   function automatic void model_step();
      bit fb;
      int since;
      m_pos = 1'b0;
      m_neg = 1'b0;
      if (reset_i) begin
         model_reset();
         return;
      end
      if (!enable_i) begin
         m_cnt      = 0;
         m_lock     = 0;
         m_locked   = 1'b0;
         last_pulse = -1000;
         if (edge_n_q.size() > 0 && edge_n_q[0] + 2 == cyc) begin
            void'(edge_n_q.pop_front());
            void'(edge_fb_q.pop_front());
         end
         return;
      end
      if (edge_n_q.size() > 0 && edge_n_q[0] + 2 == cyc) begin
         void'(edge_n_q.pop_front());
         fb     = edge_fb_q.pop_front();
         m_lock = (m_lock < LOCK_EDGES) ? m_lock + 1 : LOCK_EDGES;
         // edge cycle starts at cyc-1; it is discarded within HOLDOFF cycles after a pulse
         since  = (cyc - 1) - last_pulse;
         if (!(since >= 1 && since <= HOLDOFF)) begin
            m_cnt = fb ? m_cnt - 1 : m_cnt + 1;
            if (m_cnt == K) begin
               m_pos      = 1'b1;
               m_cnt      = 0;
               last_pulse = cyc;
            end else if (m_cnt == -K) begin
               m_neg      = 1'b1;
               m_cnt      = 0;
               last_pulse = cyc;
            end
         end
         m_locked = (m_lock == LOCK_EDGES);
      end
      if (cyc == last_pulse + 1) begin
         m_lock   = 0;
         m_locked = 1'b0;
      end
   endfunction

   task automatic clear_obs();
      bad_cycles  = 0;
      pos_seen    = 0;
      neg_seen    = 0;
      both_seen   = 0;
      locked_seen = 0;
   endtask

   task automatic tick();
      logic [W+2:0] obs;
      logic [W+2:0] expv;
      @(posedge clk_i);
      cyc++;
      model_step();
      #1;
      obs  = {positiveShift_o, negativeShift_o, locked_o, vote_cnt_o};
      expv = {m_pos, m_neg, m_locked, W'(m_cnt)};
      if (obs !== expv) begin
         if (bad_cycles == 0) begin
            first_bad_cyc = cyc;
            first_bad_obs = obs;
            first_bad_exp = expv;
         end
         bad_cycles++;
      end
      if (positiveShift_o === 1'b1) pos_seen++;
      if (negativeShift_o === 1'b1) neg_seen++;
      if (positiveShift_o === 1'b1 && negativeShift_o === 1'b1) both_seen++;
      if (locked_o === 1'b1) locked_seen++;
   endtask

   // One ref period starting now; returns outputs seen the cycle the vote lands
   task automatic ref_edge(input bit fb, input int period, output logic [W-1:0] cnt_seen,
                           output logic pos_e, output logic neg_e, output logic lck_e);
      int c0;
      c0       = cyc;
      cnt_seen = 'x;
      pos_e    = 1'bx;
      neg_e    = 1'bx;
      lck_e    = 1'bx;
      ref_i    = 1'b1;
      fb_i     = fb;
      edge_n_q.push_back(c0 + 1);
      edge_fb_q.push_back(fb);
      for (int i = 0; i < period; i++) begin
         if (i == period / 2) ref_i = 1'b0;
         tick();
         if (cyc == c0 + 3) begin
            cnt_seen = vote_cnt_o;
            pos_e    = positiveShift_o;
            neg_e    = negativeShift_o;
            lck_e    = locked_o;
         end
      end
   endtask

   task automatic test_reset();
      clear_obs();
      reset_i  = 1'b1;
      enable_i = 1'b1;
      ref_i    = 1'b0;
      fb_i     = 1'b0;
      model_reset();
      repeat (3) tick();
      n_checks++;
      if ({positiveShift_o, negativeShift_o, locked_o, vote_cnt_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 0", {positiveShift_o, negativeShift_o, locked_o, vote_cnt_o});
      end
      reset_i = 1'b0;
      repeat (4) tick();
      n_checks++;
      if (bad_cycles !== 0) begin
         n_fail++;
         $display("FAIL reset_model: %0d bad cycles, first %0d got %b want %b", bad_cycles, first_bad_cyc, first_bad_obs, first_bad_exp);
      end
   endtask

   task automatic test_late_feedback();
      logic [W-1:0] c;
      logic pe, ne, le;
      clear_obs();
      for (int i = 1; i <= 12; i++) begin
         ref_edge(1'b0, $urandom_range(20, 100), c, pe, ne, le);
         n_checks++;
         if (c !== W'(i % 4) || pe !== (i % 4 == 0) || ne !== 1'b0) begin
            n_fail++;
            $display("FAIL late_edge%0d: got cnt=%0d pos=%b neg=%b want cnt=%0d pos=%b neg=0", i, c, pe, ne, i % 4, (i % 4 == 0));
         end
      end
      n_checks++;
      if (pos_seen !== 3 || neg_seen !== 0 || bad_cycles !== 0) begin
         n_fail++;
         $display("FAIL late_summary: pos=%0d neg=%0d bad=%0d want pos=3 neg=0 bad=0", pos_seen, neg_seen, bad_cycles);
      end
   endtask

   task automatic test_early_feedback();
      logic [W-1:0] c;
      logic pe, ne, le;
      clear_obs();
      for (int i = 1; i <= 12; i++) begin
         ref_edge(1'b1, $urandom_range(20, 100), c, pe, ne, le);
         n_checks++;
         if (c !== W'(-(i % 4)) || ne !== (i % 4 == 0) || pe !== 1'b0) begin
            n_fail++;
            $display("FAIL early_edge%0d: got cnt=%0d pos=%b neg=%b want cnt=-%0d neg=%b pos=0", i, $signed(c), pe, ne, i % 4, (i % 4 == 0));
         end
      end
      n_checks++;
      if (neg_seen !== 3 || pos_seen !== 0 || locked_seen !== 0 || bad_cycles !== 0) begin
         n_fail++;
         $display("FAIL early_summary: neg=%0d pos=%0d locked=%0d bad=%0d want 3/0/0/0", neg_seen, pos_seen, locked_seen, bad_cycles);
      end
   endtask

   task automatic test_balanced();
      logic [W-1:0] c;
      logic pe, ne, le;
      clear_obs();
      enable_i = 1'b0;
      repeat (3) tick();
      enable_i = 1'b1;
      tick();
      for (int i = 1; i <= 16; i++) begin
         ref_edge(i % 2 == 0, $urandom_range(10, 40), c, pe, ne, le);
         n_checks++;
         if (c !== W'(i % 2) || le !== (i >= LOCK_EDGES)) begin
            n_fail++;
            $display("FAIL balanced_edge%0d: got cnt=%0d locked=%b want cnt=%0d locked=%b", i, c, le, i % 2, (i >= LOCK_EDGES));
         end
      end
      n_checks++;
      if (pos_seen !== 0 || neg_seen !== 0 || locked_o !== 1'b1 || bad_cycles !== 0) begin
         n_fail++;
         $display("FAIL balanced_summary: pos=%0d neg=%0d locked=%b bad=%0d want 0/0/1/0", pos_seen, neg_seen, locked_o, bad_cycles);
      end
   endtask

   task automatic test_holdoff();
      logic [W-1:0] c;
      logic pe, ne, le;
      int cnt_tab[5] = '{1, 2, 3, 0, 0};
      int j;
      clear_obs();
      for (int i = 1; i <= 20; i++) begin
         ref_edge(1'b0, 4, c, pe, ne, le);
         j = (i - 1) % 5;
         n_checks++;
         if (c !== W'(cnt_tab[j]) || pe !== (j == 3) || le !== (i <= 4)) begin
            n_fail++;
            $display("FAIL holdoff_edge%0d: got cnt=%0d pos=%b locked=%b want cnt=%0d pos=%b locked=%b", i, c, pe, le, cnt_tab[j], (j == 3), (i <= 4));
         end
      end
      n_checks++;
      if (pos_seen !== 4 || neg_seen !== 0 || bad_cycles !== 0) begin
         n_fail++;
         $display("FAIL holdoff_summary: pos=%0d neg=%0d bad=%0d want 4/0/0", pos_seen, neg_seen, bad_cycles);
      end
   endtask

   task automatic test_enable_drop();
      logic [W-1:0] c;
      logic pe, ne, le;
      clear_obs();
      for (int i = 1; i <= 3; i++) ref_edge(1'b0, $urandom_range(6, 30), c, pe, ne, le);
      n_checks++;
      if (vote_cnt_o !== W'(3)) begin
         n_fail++;
         $display("FAIL enable_pre_count: got %0d want 3", vote_cnt_o);
      end
      enable_i = 1'b0;
      tick();
      n_checks++;
      if ({positiveShift_o, negativeShift_o, locked_o, vote_cnt_o} !== '0) begin
         n_fail++;
         $display("FAIL enable_drop: got %b want 0", {positiveShift_o, negativeShift_o, locked_o, vote_cnt_o});
      end
      repeat (5) tick();
      enable_i = 1'b1;
      repeat (2) tick();
      for (int i = 1; i <= 4; i++) begin
         ref_edge(1'b0, $urandom_range(6, 30), c, pe, ne, le);
         n_checks++;
         if (c !== W'(i % 4) || pe !== (i == 4)) begin
            n_fail++;
            $display("FAIL enable_resume_edge%0d: got cnt=%0d pos=%b want cnt=%0d pos=%b", i, c, pe, i % 4, (i == 4));
         end
      end
      n_checks++;
      if (pos_seen !== 1 || neg_seen !== 0 || bad_cycles !== 0) begin
         n_fail++;
         $display("FAIL enable_summary: pos=%0d neg=%0d bad=%0d want 1/0/0", pos_seen, neg_seen, bad_cycles);
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] c;
      logic pe, ne, le;
      int c0;
      clear_obs();
      for (int i = 1; i <= 3; i++) ref_edge(1'b1, $urandom_range(6, 30), c, pe, ne, le);
      // fourth early edge: its vote would fire negativeShift_o
      c0    = cyc;
      ref_i = 1'b1;
      fb_i  = 1'b1;
      edge_n_q.push_back(c0 + 1);
      edge_fb_q.push_back(1'b1);
      tick();
      tick();
      n_checks++;
      if (vote_cnt_o !== W'(-3)) begin
         n_fail++;
         $display("FAIL reset_mid_pre_count: got %0d want -3", $signed(vote_cnt_o));
      end
      #1;
      reset_i = 1'b1;
      ref_i   = 1'b0;
      fb_i    = 1'b0;
      #1;
      n_checks++;
      if ({positiveShift_o, negativeShift_o, locked_o, vote_cnt_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_immediate: got %b want 0", {positiveShift_o, negativeShift_o, locked_o, vote_cnt_o});
      end
      model_reset();
      repeat (3) tick();
      #1;
      reset_i = 1'b0;
      repeat (3) tick();
      for (int i = 1; i <= 8; i++) begin
         ref_edge(1'b0, $urandom_range(6, 30), c, pe, ne, le);
         n_checks++;
         if (c !== W'(i % 4) || pe !== (i % 4 == 0)) begin
            n_fail++;
            $display("FAIL reset_mid_edge%0d: got cnt=%0d pos=%b want cnt=%0d pos=%b", i, c, pe, i % 4, (i % 4 == 0));
         end
      end
      n_checks++;
      if (pos_seen !== 2 || neg_seen !== 0 || bad_cycles !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_summary: pos=%0d neg=%0d bad=%0d want 2/0/0", pos_seen, neg_seen, bad_cycles);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] c;
      logic pe, ne, le;
      clear_obs();
      for (int i = 0; i < 80; i++) begin
         ref_edge(1'($urandom_range(0, 1)), $urandom_range(4, 24), c, pe, ne, le);
         if ($urandom_range(0, 5) == 0) begin
            enable_i = 1'b0;
            repeat ($urandom_range(1, 4)) tick();
            enable_i = 1'b1;
         end
      end
      n_checks++;
      if (bad_cycles !== 0) begin
         n_fail++;
         $display("FAIL random_model: %0d bad cycles, first %0d got %b want %b", bad_cycles, first_bad_cyc, first_bad_obs, first_bad_exp);
      end
      n_checks++;
      if (both_seen !== 0) begin
         n_fail++;
         $display("FAIL random_exclusive: both pulses high in %0d cycles, want 0", both_seen);
      end
   endtask

   initial begin
      reset_i  = 1'b1;
      enable_i = 1'b0;
      ref_i    = 1'b0;
      fb_i     = 1'b0;
      model_reset();
      test_reset();
      test_late_feedback();
      test_early_feedback();
      test_balanced();
      test_holdoff();
      test_enable_drop();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
